// File: rtl/roba_pkg.sv
// roba_pkg: exponent-width helper and stage-1 payload type shared by the rounding unit
package roba_pkg;

   localparam int MAX_W = 64;

   function automatic int exp_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int MAX_EW = exp_width(MAX_W);

   // Sized for the widest legal operand; narrower instances use the low bits only
   typedef struct packed {
      logic [MAX_W-1:0]  data;
      logic [MAX_EW-1:0] k;
      logic              rbit;
      logic              zero;
   } s1_t;

endpackage

// File: rtl/roba_lod.sv
// roba_lod: combinational leading-one detector returning the highest set bit index and a zero flag
module roba_lod
   import roba_pkg::*;
#(
   parameter  int W  = 32,
   localparam int EW = exp_width(W)
) (
   input  logic [W-1:0]  data_i,
   output logic [EW-1:0] idx_o,
   output logic          zero_o
);

   // Ascending scan so the last set bit seen is the most significant one
   always_comb begin
      idx_o  = '0;
      zero_o = ~|data_i;
      for (int i = 0; i < W; i++)
         if (data_i[i]) idx_o = EW'(i);
   end

endmodule

// File: rtl/roba_round_unit.sv
// roba_round_unit: two-stage pipeline rounding an unsigned operand to its nearest power of two
// Optional macro ROBA_RESIDUAL_EN adds out_res = in_data - out_pow (signed, W+2 bits)
module roba_round_unit
   import roba_pkg::*;
#(
   parameter  int W  = 32,
   localparam int EW = exp_width(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [EW-1:0] out_exp,
   output logic [W:0]    out_pow,
   output logic          out_zero
`ifdef ROBA_RESIDUAL_EN
   ,
   output logic [W+1:0]  out_res
`endif
);

   logic [EW-1:0] lod_k;
   logic          lod_zero;
   logic [W:0]    data_sh;
   s1_t           s1_q, s1_d;
   logic          v1_q, v1_d, v2_q, v2_d;
   logic [EW-1:0] exp_q, exp_d, exp_c, k1;
   logic [W:0]    pow_q, pow_d, pow_c;
   logic          zero_q, zero_d;
   logic [W-1:0]  d1;
   logic          adv2, take1, load2;
   logic          unused_s1;

   roba_lod #(.W(W)) u_lod (
      .data_i (in_data),
      .idx_o  (lod_k),
      .zero_o (lod_zero)
   );

   assign adv2      = ~v2_q | out_ready;
   assign in_ready  = ~v1_q | adv2;
   assign take1     = in_valid & in_ready;
   assign load2     = v1_q & adv2;
   assign data_sh   = {in_data, 1'b0};
   assign k1        = s1_q.k[EW-1:0];
   assign d1        = s1_q.data[W-1:0];
   assign unused_s1 = ^{s1_q.data, s1_q.k};
   assign exp_c     = k1 + EW'(s1_q.rbit);
   assign pow_c     = s1_q.zero ? '0 : (W+1)'(1) << exp_c;

   // Stage 1 captures the leading-one index and the bit just below it (data_sh[k] = in_data[k-1], 0 at k=0)
   always_comb begin
      s1_d = s1_q;
      v1_d = in_ready ? in_valid : v1_q;
      if (take1) begin
         s1_d                 = '0;
         s1_d.data[W-1:0]     = in_data;
         s1_d.k[EW-1:0]       = lod_k;
         s1_d.rbit            = data_sh[lod_k];
         s1_d.zero            = lod_zero;
      end
   end

   // Stage 2 forms the rounded exponent and power; values hold while the consumer stalls
   always_comb begin
      v2_d   = adv2 ? v1_q : v2_q;
      exp_d  = load2 ? exp_c : exp_q;
      pow_d  = load2 ? pow_c : pow_q;
      zero_d = load2 ? s1_q.zero : zero_q;
   end

   // Pipeline registers; reset empties both stages at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         exp_q  <= '0;
         pow_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         exp_q  <= exp_d;
         pow_q  <= pow_d;
         zero_q <= zero_d;
      end
   end

`ifdef ROBA_RESIDUAL_EN
   logic [W+1:0] res_q, res_d, res_c;

   assign res_c = {2'b00, d1} - {1'b0, pow_c};

   // Residual rides alongside the stage-2 result
   always_comb begin
      res_d = load2 ? res_c : res_q;
   end

   // Residual register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) res_q <= '0;
      else      res_q <= res_d;
   end

   assign out_res = res_q;
`else
   logic unused_d1;
   assign unused_d1 = ^d1;
`endif

   assign out_valid = v2_q;
   assign out_exp   = exp_q;
   assign out_pow   = pow_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_roba_round_unit.sv
// tb_roba_round_unit: directed and scoreboarded checks of the nearest-power-of-two rounding pipeline
module tb_roba_round_unit;

   localparam int W  = 32;
   localparam int EW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [EW-1:0] out_exp;
   logic [W:0]    out_pow;
   logic          out_zero;
`ifdef ROBA_RESIDUAL_EN
   logic [W+1:0]  out_res;
`endif

   int            n_chk = 0;
   int            n_fail = 0;
   logic [W-1:0]  sb[$];

   roba_round_unit #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_exp   (out_exp),
      .out_pow   (out_pow),
      .out_zero  (out_zero)
`ifdef ROBA_RESIDUAL_EN
      ,
      .out_res   (out_res)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, want);
      end
   endtask

   // Reference: {exp[5:0], pow[32:0], zero}
   function automatic logic [39:0] model(input logic [W-1:0] d);
      int         k = 0;
      int         e;
      logic [W:0] p;
      for (int i = 0; i < W; i++)
         if (d[i]) k = i;
      e = k + ((k > 0 && d[k-1]) ? 1 : 0);
      p = (d == 0) ? '0 : ((W+1)'(1) << e);
      return {e[5:0], p, d == 0};
   endfunction

   function automatic logic [33:0] model_res(input logic [W-1:0] d);
      logic [39:0] m = model(d);
      return {2'b00, d} - {1'b0, m[33:1]};
   endfunction

   task automatic one(input logic [W-1:0] d, input int e, input logic [W:0] p, input logic z, input longint r);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1;
      #1 chk("one_rdy", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("one_lat1", out_valid, 0);
      @(negedge clk);
      chk("one_lat2", out_valid, 1);
      chk("one_exp", out_exp, e);
      chk("one_pow", out_pow, p);
      chk("one_zero", out_zero, z);
`ifdef ROBA_RESIDUAL_EN
      chk("one_res", out_res, r[33:0]);
`else
      begin
         logic unused_r;
         unused_r = ^r;
      end
`endif
      @(negedge clk);
      chk("one_drain", out_valid, 0);
   endtask

   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input string tag);
      logic [W-1:0] w;
      @(negedge clk);
      in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk({tag, "_extra"}, 1, 0);
         else begin
            w = sb.pop_front();
            chk(tag, {out_exp, out_pow, out_zero}, model(w));
`ifdef ROBA_RESIDUAL_EN
            chk({tag, "_res"}, out_res, model_res(w));
`endif
         end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
   endtask

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] d = $urandom;
      case ($urandom_range(0, 3))
         0: d = d >> $urandom_range(0, 31);
         1: d = $urandom_range(0, 8);
         default: ;
      endcase
      return d;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_exp", out_exp, 0);
      chk("rst_pow", out_pow, 0);
      chk("rst_zero", out_zero, 0);
`ifdef ROBA_RESIDUAL_EN
      chk("rst_res", out_res, 0);
`endif
      rst = 1'b1;

      one(32'd6, 3, 33'd8, 0, -2);
      one(32'd5, 2, 33'd4, 0, 1);
      one(32'd0, 0, 33'd0, 1, 0);
      one(32'd1, 0, 33'd1, 0, 0);
      one(32'd3, 2, 33'd4, 0, -1);
      one(32'd7, 3, 33'd8, 0, -1);
      one(32'd2, 1, 33'd2, 0, 0);
      one(32'hC000_0000, 32, 33'h1_0000_0000, 0, -(64'sd1 << 30));
      one(32'hFFFF_FFFF, 32, 33'h1_0000_0000, 0, -1);
      one(32'h8000_0000, 31, 33'h0_8000_0000, 0, 0);

      // Backpressure: two accepted, third stalls, results drain in order
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
      #1 chk("bp_rdy0", in_ready, 1);
      @(negedge clk);
      in_data = 32'd2;
      #1 chk("bp_rdy1", in_ready, 1);
      @(negedge clk);
      in_data = 32'd3;
      #1 chk("bp_full", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_exp0", out_exp, 0);
      @(negedge clk);
      chk("bp_still", in_ready, 0);
      chk("bp_hold_exp", out_exp, 0);
      chk("bp_hold_pow", out_pow, 1);
      out_ready = 1'b1;
      #1 chk("bp_release", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_v1", out_valid, 1);
      chk("bp_exp1", out_exp, 1);
      @(negedge clk);
      chk("bp_v2", out_valid, 1);
      chk("bp_exp2", out_exp, 2);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);

      // Full-rate stream
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, rnd(), 1'b1, "stream");
         if (i >= 2) chk("stream_rate", out_valid, 1);
      end
      // Random valid/ready traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), "rand");
      for (int i = 0; i < 10; i++)
         step(1'b0, '0, 1'b1, "drain");
      chk("sb_empty", sb.size(), 0);

      // Reset with both stages full discards them; first edge after release accepts
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
      @(negedge clk);
      in_data = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mr_full", out_valid, 1);
      rst = 1'b0;
      #1 chk("mr_valid", out_valid, 0);
      chk("mr_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 32'd4; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mr_lat1", out_valid, 0);
      @(negedge clk);
      chk("mr_new", out_valid, 1);
      chk("mr_exp", out_exp, 2);
      chk("mr_pow", out_pow, 4);
      @(negedge clk);
      chk("mr_nostale", out_valid, 0);
      @(negedge clk);
      chk("mr_nostale2", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/roba_round_unit.md
ROBA_ROUND_UNIT -- requirements
Module: roba_round_unit

Interface
REQ-001 Parameter: W, 32, operand width in bits; legal range 4..64.
REQ-002 Parameter: EW, $clog2(W)+1, exponent width; derived, never overridden.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand present.
REQ-006 in_ready  output  1  unit accepts operand this cycle.
REQ-007 in_data  input  W  unsigned operand.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 out_exp  output  EW  exponent of nearest power of two.
REQ-011 out_pow  output  W+1  2**out_exp; zero when out_zero=1.
REQ-012 out_zero  output  1  operand was zero.
REQ-013 out_res  output  W+2  signed residual in_data - out_pow (only with macro, REQ-030).

Function
REQ-014 Transfer on a port SHALL occur only when valid and ready are both high on a rising edge.
REQ-015 Two-stage pipeline: stage 1 registers leading-one index k (highest set bit), bit in_data[k-1] (0 when k=0), zero flag, and operand; stage 2 registers rounded result.
REQ-016 Rounding SHALL be: out_exp = k+1 if in_data[k-1]=1, else k; tie 3*2**(k-1) rounds up.
REQ-017 k=W-1 with round-up SHALL give out_exp=W, out_pow=2**W (carry bit W of out_pow), no wrap.
REQ-018 in_data=0 SHALL give out_zero=1, out_exp=0, out_pow=0, out_res=0.
REQ-019 in_data=1 SHALL give out_exp=0, out_pow=1, out_zero=0.
REQ-020 Latency: accepted operand appears on out_valid exactly 2 cycles later when out_ready stays high; throughput 1 operand/cycle.
REQ-021 Each stage SHALL advance when its successor is empty or its successor transfers the same cycle; in_ready = stage-1 empty or stage-1 advancing (combinational from out_ready, no combinational path from in_valid).
REQ-022 While out_valid=1 and out_ready=0, out_exp/out_pow/out_zero/out_res SHALL hold stable.
REQ-023 No operand SHALL be dropped or duplicated; output order equals input order.
REQ-024 Simultaneous input and output transfer with both stages full SHALL be accepted (full-rate streaming under continuous out_ready).
REQ-025 Pipeline capacity SHALL be exactly 2 operands; third operand stalls (in_ready=0) under backpressure.

Reset
REQ-026 rst low SHALL immediately clear both stage valid flags; out_valid=0, in_ready=1 after release.
REQ-027 Reset values: out_exp=0, out_pow=0, out_zero=0, out_res=0.
REQ-028 Reset mid-operation SHALL discard in-flight operands; no result for them appears after release.
REQ-029 First transfer permitted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro ROBA_RESIDUAL_EN: defined -> out_res port present and computed in stage 2 as signed in_data - out_pow; undefined -> port absent, no residual logic, all other behaviour identical.

Structure
REQ-031 Package roba_pkg SHALL hold function exp_width(W) = $clog2(W)+1 and typedef of the stage-1 payload struct.
REQ-032 Sub-module roba_lod SHALL implement combinational leading-one detect (W-bit in, EW-bit index, zero flag); instantiated once in stage 1.

Verification
REQ-033 in_data=6, out_ready=1 -> 2 cycles later out_exp=3, out_pow=8, out_zero=0, out_res=-2.
REQ-034 in_data=5 -> out_exp=2, out_pow=4, out_res=+1; in_data=0 -> out_zero=1, out_pow=0.
REQ-035 W=32, in_data=32'hC000_0000 -> out_exp=32, out_pow=33'h1_0000_0000, out_res=-2**30.
REQ-036 Feed 1,2,3 back-to-back with out_ready=0 -> in_ready low after 2 accepted, third held; raise out_ready -> results exp 0,1,2 in order, no loss.
REQ-037 Continuous random stream with out_ready=1 for 1000 cycles -> one result per cycle, all match reference model.
REQ-038 Assert rst low with both stages full -> out_valid=0 immediately; after release no stale result emerges.
